// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   - state_e             : receiver FSM state encoding
//   - DATA_WIDTH_DEFAULT  : default data bits per frame
//   - OVERSAMPLE_DEFAULT  : default baud_tick pulses per bit period
//   - mid_count()         : tick count at which the middle of a bit falls
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam int DATA_WIDTH_DEFAULT = 8;
  localparam int OVERSAMPLE_DEFAULT = 16;

  // Counting starts when the falling edge of the start bit is first seen, so
  // half a bit period later is the centre of the start bit.
  function automatic int mid_count(input int oversample);
    return oversample / 2 - 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous input. Both flops reset to
// 1 so an idle-high serial line never shows a false low edge out of reset.
// Ports:
//   clk      in   destination clock
//   reset_n  in   asynchronous active-low reset
//   d        in   asynchronous input
//   q        out  synchronised output (2 clk latency)
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx_framer.sv
// -----------------------------------------------------------------------------
// uart_rx_framer
// UART receive front-end: synchronises rx, qualifies the start bit at its
// centre, samples each data bit at mid-bit on an oversampling tick, streams
// each bit out as bit_out/bit_valid (shift enable for a downstream sipo), and
// assembles the LSB-first frame, reporting a byte or a framing error.
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   baud_tick   in   one-clk pulse at OVERSAMPLE x baud rate
//   rx          in   asynchronous serial line, idles high
//   bit_valid   out  one-clk strobe per sampled data bit
//   bit_out     out  sampled data bit, valid with bit_valid
//   data_out    out  last good frame, LSB = first bit received
//   data_valid  out  one-clk pulse when data_out updates
//   frame_err   out  one-clk pulse when the stop bit is sampled low
//   busy        out  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  baud_tick,
  input  logic                  rx,
  output logic                  bit_valid,
  output logic                  bit_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_START = START;
  localparam logic [1:0] S_DATA  = DATA;
  localparam logic [1:0] S_STOP  = STOP;

  localparam logic [CW-1:0] CNT_MID  = CW'(mid_count(OVERSAMPLE));
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_WIDTH - 1);

  logic rx_s;

  sync_2ff u_sync_rx (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  logic [1:0]            state_reg,      state_next;
  logic [CW-1:0]         cnt_reg,        cnt_next;
  logic [BW-1:0]         bit_idx_reg,    bit_idx_next;
  logic [DATA_WIDTH-1:0] shift_reg,      shift_next;
  logic                  bit_valid_reg,  bit_valid_next;
  logic                  bit_out_reg,    bit_out_next;
  logic [DATA_WIDTH-1:0] data_out_reg,   data_out_next;
  logic                  data_valid_reg, data_valid_next;
  logic                  frame_err_reg,  frame_err_next;
  logic                  busy_reg,       busy_next;

  // Right shift: each new bit enters at the MSB so the first bit received
  // ends up in the LSB after DATA_WIDTH samples.
  logic [DATA_WIDTH-1:0] shift_in;

  generate
    for (genvar gi = 0; gi < DATA_WIDTH - 1; gi++) begin : g_shift
      assign shift_in[gi] = shift_reg[gi+1];
    end
  endgenerate
  assign shift_in[DATA_WIDTH-1] = rx_s;

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    bit_idx_next    = bit_idx_reg;
    shift_next      = shift_reg;
    bit_out_next    = bit_out_reg;
    bit_valid_next  = 1'b0;
    data_out_next   = data_out_reg;
    data_valid_next = 1'b0;
    frame_err_next  = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (baud_tick && !rx_s) begin
          state_next   = S_START;
          cnt_next     = '0;
          bit_idx_next = '0;
        end
      end

      S_START: begin
        if (baud_tick) begin
          if (cnt_reg == CNT_MID) begin
            // Line must still be low at the centre of the start bit;
            // otherwise the edge was a glitch and we quietly re-arm.
            state_next   = rx_s ? S_IDLE : S_DATA;
            cnt_next     = '0;
            bit_idx_next = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (baud_tick) begin
          if (cnt_reg == CNT_LAST) begin
            cnt_next       = '0;
            bit_out_next   = rx_s;
            bit_valid_next = 1'b1;
            shift_next     = shift_in;
            if (bit_idx_reg == IDX_LAST) begin
              state_next   = S_STOP;
              bit_idx_next = '0;
            end else begin
              bit_idx_next = bit_idx_reg + 1'b1;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      S_STOP: begin
        if (baud_tick) begin
          if (cnt_reg == CNT_LAST) begin
            if (rx_s) begin
              data_out_next   = shift_reg;
              data_valid_next = 1'b1;
            end else begin
              frame_err_next  = 1'b1;
            end
            // Returning to IDLE here lets a start bit that immediately
            // follows the stop bit be picked up without a dead period.
            state_next   = S_IDLE;
            cnt_next     = '0;
            bit_idx_next = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      default: begin
        state_next   = S_IDLE;
        cnt_next     = '0;
        bit_idx_next = '0;
      end
    endcase

    busy_next = (state_next != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      bit_valid_reg  <= 1'b0;
      bit_out_reg    <= 1'b0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      bit_idx_reg    <= bit_idx_next;
      shift_reg      <= shift_next;
      bit_valid_reg  <= bit_valid_next;
      bit_out_reg    <= bit_out_next;
      data_out_reg   <= data_out_next;
      data_valid_reg <= data_valid_next;
      frame_err_reg  <= frame_err_next;
      busy_reg       <= busy_next;
    end
  end

  assign bit_valid  = bit_valid_reg;
  assign bit_out    = bit_out_reg;
  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;
  assign frame_err  = frame_err_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_uart_rx_framer.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_framer
// Directed bench for uart_rx_framer with DATA_WIDTH=8, OVERSAMPLE=16.
// A monitor samples DUT outputs on the falling clock edge and keeps running
// counts; each scenario task snapshots the counts and checks the deltas.
// -----------------------------------------------------------------------------
module tb_uart_rx_framer;

  logic       clk;
  logic       reset_n;
  logic       baud_tick;
  logic       rx;
  logic       bit_valid;
  logic       bit_out;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  int tick_div  = 1;
  int exp_space = 16;

  // monitor state (written only by the monitor process)
  int         cyc        = 0;
  int         bv_cnt     = 0;
  int         dv_cnt     = 0;
  int         fe_cnt     = 0;
  int         busy_cnt   = 0;
  int         space_err  = 0;
  int         wide_err   = 0;
  int         both_err   = 0;
  int         last_bv    = 0;
  bit         have_prev  = 0;
  logic       dv_prev    = 0;
  logic       fe_prev    = 0;
  logic [7:0] sipo       = '0;
  logic       bit_seq [0:63];
  logic [7:0] dv_hist [0:63];

  uart_rx_framer #(
    .DATA_WIDTH (8),
    .OVERSAMPLE (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .baud_tick  (baud_tick),
    .rx         (rx),
    .bit_valid  (bit_valid),
    .bit_out    (bit_out),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // baud tick generator: every clk when tick_div==1, else one in tick_div
  initial begin
    int ph;
    ph = 0;
    baud_tick = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (tick_div <= 1) begin
        baud_tick = 1'b1;
      end else begin
        baud_tick = (ph == 0);
        ph = (ph + 1) % tick_div;
      end
    end
  end

  // output monitor, also acts as the downstream sipo model
  initial begin
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (!reset_n) have_prev = 0;
      if (bit_valid) begin
        if (have_prev && (cyc - last_bv) != exp_space) space_err = space_err + 1;
        have_prev = 1;
        last_bv = cyc;
        bit_seq[bv_cnt % 64] = bit_out;
        bv_cnt = bv_cnt + 1;
        sipo = {bit_out, sipo[7:1]};
      end
      if (data_valid) begin
        dv_hist[dv_cnt % 64] = data_out;
        dv_cnt = dv_cnt + 1;
        have_prev = 0;
      end
      if (frame_err) begin
        fe_cnt = fe_cnt + 1;
        have_prev = 0;
      end
      if (data_valid && frame_err) both_err = both_err + 1;
      if ((data_valid && dv_prev) || (frame_err && fe_prev)) wide_err = wide_err + 1;
      dv_prev = data_valid;
      fe_prev = frame_err;
      if (busy) busy_cnt = busy_cnt + 1;
    end
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (16 * tick_div) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_bit);
    rx = 1'b1;
  endtask

  task automatic idle_clks(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bit_valid !== 1'b0) begin n_bad++; $display("FAIL reset_bit_valid got=%b exp=0", bit_valid); end
    n_cmp++; if (bit_out !== 1'b0) begin n_bad++; $display("FAIL reset_bit_out got=%b exp=0", bit_out); end
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_data_valid got=%b exp=0", data_valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset_n = 1'b1;
    idle_clks(10);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
    $display("reset: checked outputs during and after reset");
  endtask

  task automatic test_good_frame();
    int bv0, dv0, fe0, sp0, wd0, bt0;
    logic [7:0] exp_bits;
    exp_bits = 8'hA5;
    bv0 = bv_cnt; dv0 = dv_cnt; fe0 = fe_cnt; sp0 = space_err; wd0 = wide_err; bt0 = both_err;
    send_frame(8'hA5, 1'b1);
    idle_clks(40);
    n_cmp++; if (bv_cnt - bv0 != 8) begin n_bad++; $display("FAIL a5_bit_count got=%0d exp=8", bv_cnt - bv0); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (bit_seq[(bv0 + i) % 64] !== exp_bits[i]) begin
        n_bad++; $display("FAIL a5_bit%0d got=%b exp=%b", i, bit_seq[(bv0 + i) % 64], exp_bits[i]);
      end
    end
    n_cmp++; if (data_out !== 8'hA5) begin n_bad++; $display("FAIL a5_data_out got=%h exp=a5", data_out); end
    n_cmp++; if (dv_cnt - dv0 != 1) begin n_bad++; $display("FAIL a5_data_valid_count got=%0d exp=1", dv_cnt - dv0); end
    n_cmp++; if (fe_cnt - fe0 != 0) begin n_bad++; $display("FAIL a5_frame_err_count got=%0d exp=0", fe_cnt - fe0); end
    n_cmp++; if (space_err - sp0 != 0) begin n_bad++; $display("FAIL a5_bit_spacing errors=%0d exp=0", space_err - sp0); end
    n_cmp++; if (wide_err - wd0 != 0) begin n_bad++; $display("FAIL a5_strobe_width errors=%0d exp=0", wide_err - wd0); end
    n_cmp++; if (both_err - bt0 != 0) begin n_bad++; $display("FAIL a5_exclusive errors=%0d exp=0", both_err - bt0); end
    $display("good_frame: sent a5, data_out=%h bits=%0d", data_out, bv_cnt - bv0);
  endtask

  task automatic test_glitch();
    int bv0, dv0, fe0, bz0;
    bv0 = bv_cnt; dv0 = dv_cnt; fe0 = fe_cnt; bz0 = busy_cnt;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle_clks(40);
    n_cmp++; if (busy_cnt - bz0 == 0) begin n_bad++; $display("FAIL glitch_busy_rose busy_cycles=%0d exp>0", busy_cnt - bz0); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_fell got=%b exp=0", busy); end
    n_cmp++; if (bv_cnt - bv0 != 0) begin n_bad++; $display("FAIL glitch_bit_valid got=%0d exp=0", bv_cnt - bv0); end
    n_cmp++; if (dv_cnt - dv0 != 0) begin n_bad++; $display("FAIL glitch_data_valid got=%0d exp=0", dv_cnt - dv0); end
    n_cmp++; if (fe_cnt - fe0 != 0) begin n_bad++; $display("FAIL glitch_frame_err got=%0d exp=0", fe_cnt - fe0); end
    $display("glitch: 4-clk low pulse, busy_cycles=%0d", busy_cnt - bz0);
  endtask

  task automatic test_frame_err();
    int dv0, fe0, wd0;
    dv0 = dv_cnt; fe0 = fe_cnt; wd0 = wide_err;
    send_frame(8'h3C, 1'b0);
    idle_clks(40);
    n_cmp++; if (fe_cnt - fe0 != 1) begin n_bad++; $display("FAIL ferr_frame_err_count got=%0d exp=1", fe_cnt - fe0); end
    n_cmp++; if (dv_cnt - dv0 != 0) begin n_bad++; $display("FAIL ferr_data_valid_count got=%0d exp=0", dv_cnt - dv0); end
    n_cmp++; if (data_out !== 8'hA5) begin n_bad++; $display("FAIL ferr_data_out_held got=%h exp=a5", data_out); end
    n_cmp++; if (wide_err - wd0 != 0) begin n_bad++; $display("FAIL ferr_strobe_width errors=%0d exp=0", wide_err - wd0); end
    $display("frame_err: sent 3c with low stop, data_out=%h", data_out);
  endtask

  task automatic test_back_to_back();
    int bv0, dv0, fe0, sp0;
    bv0 = bv_cnt; dv0 = dv_cnt; fe0 = fe_cnt; sp0 = space_err;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle_clks(40);
    n_cmp++; if (dv_cnt - dv0 != 2) begin n_bad++; $display("FAIL b2b_data_valid_count got=%0d exp=2", dv_cnt - dv0); end
    n_cmp++; if (dv_hist[dv0 % 64] !== 8'h00) begin n_bad++; $display("FAIL b2b_first_byte got=%h exp=00", dv_hist[dv0 % 64]); end
    n_cmp++; if (dv_hist[(dv0 + 1) % 64] !== 8'hFF) begin n_bad++; $display("FAIL b2b_second_byte got=%h exp=ff", dv_hist[(dv0 + 1) % 64]); end
    n_cmp++; if (bv_cnt - bv0 != 16) begin n_bad++; $display("FAIL b2b_bit_count got=%0d exp=16", bv_cnt - bv0); end
    n_cmp++; if (fe_cnt - fe0 != 0) begin n_bad++; $display("FAIL b2b_frame_err got=%0d exp=0", fe_cnt - fe0); end
    n_cmp++; if (space_err - sp0 != 0) begin n_bad++; $display("FAIL b2b_bit_spacing errors=%0d exp=0", space_err - sp0); end
    $display("back_to_back: sent 00 then ff, data_out=%h", data_out);
  endtask

  task automatic test_reset_abort();
    int bv0, dv0, fe0;
    logic [7:0] d;
    d = 8'h33;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    rx = d[3];
    repeat (8) @(posedge clk);
    #1;
    bv0 = bv_cnt; dv0 = dv_cnt; fe0 = fe_cnt;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy_in_reset got=%b exp=0", busy); end
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL abort_data_out_in_reset got=%h exp=00", data_out); end
    reset_n = 1'b1;
    idle_clks(40);
    n_cmp++; if (bv_cnt - bv0 != 0) begin n_bad++; $display("FAIL abort_bit_valid got=%0d exp=0", bv_cnt - bv0); end
    n_cmp++; if ((dv_cnt - dv0) + (fe_cnt - fe0) != 0) begin n_bad++; $display("FAIL abort_frame_strobes got=%0d exp=0", (dv_cnt - dv0) + (fe_cnt - fe0)); end
    bv0 = bv_cnt; dv0 = dv_cnt;
    send_frame(8'h5A, 1'b1);
    idle_clks(40);
    n_cmp++; if (data_out !== 8'h5A) begin n_bad++; $display("FAIL abort_next_data_out got=%h exp=5a", data_out); end
    n_cmp++; if (dv_cnt - dv0 != 1) begin n_bad++; $display("FAIL abort_next_data_valid got=%0d exp=1", dv_cnt - dv0); end
    n_cmp++; if (bv_cnt - bv0 != 8) begin n_bad++; $display("FAIL abort_next_bit_count got=%0d exp=8", bv_cnt - bv0); end
    $display("reset_abort: aborted mid-frame, then sent 5a, data_out=%h", data_out);
  endtask

  task automatic test_slow_tick();
    int bv0, dv0, sp0;
    tick_div = 4;
    exp_space = 64;
    idle_clks(20);
    bv0 = bv_cnt; dv0 = dv_cnt; sp0 = space_err;
    send_frame(8'h81, 1'b1);
    idle_clks(160);
    n_cmp++; if (bv_cnt - bv0 != 8) begin n_bad++; $display("FAIL slow_bit_count got=%0d exp=8", bv_cnt - bv0); end
    n_cmp++; if (space_err - sp0 != 0) begin n_bad++; $display("FAIL slow_bit_spacing errors=%0d exp=0 (64 clks)", space_err - sp0); end
    n_cmp++; if (data_out !== 8'h81) begin n_bad++; $display("FAIL slow_data_out got=%h exp=81", data_out); end
    n_cmp++; if (dv_cnt - dv0 != 1) begin n_bad++; $display("FAIL slow_data_valid got=%0d exp=1", dv_cnt - dv0); end
    n_cmp++; if (sipo !== 8'h81) begin n_bad++; $display("FAIL slow_sipo_parallel got=%h exp=81", sipo); end
    $display("slow_tick: tick every 4th clk, sent 81, data_out=%h sipo=%h", data_out, sipo);
  endtask

  initial begin
    reset_n = 1'b0;
    rx = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_good_frame();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_abort();
    test_slow_tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
UART receive front-end that sits directly upstream of the sipo shift register. It synchronises the raw rx line, detects and validates start bits, and samples each data bit at mid-bit using a 16x oversampling tick. Each sampled bit goes out as a serial bit plus strobe to feed sipo. The block also assembles and checks a complete LSB-first frame, reporting either a received byte or a framing error.

Parameters:
DATA_WIDTH, 8, data bits per frame (no parity); must be >= 2.
OVERSAMPLE, 16, baud_tick pulses per bit period; must be even and >= 4.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
baud_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate, from the baud generator
rx  input  1  asynchronous serial line; idles high
bit_valid  output  1  one-clk strobe when a data bit is sampled; shift enable for sipo
bit_out  output  1  sampled data bit; valid while bit_valid=1
data_out  output  DATA_WIDTH  last good frame, LSB = first data bit received
data_valid  output  1  one-clk pulse when data_out updates
frame_err  output  1  one-clk pulse when the stop bit is sampled low
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, rx sync flops=1, counters=0, shift register=0.
  - All outputs 0; data_out=0.
- rx passes through a 2-flop synchroniser (rx_s); all decisions use rx_s.
- Counters advance only on cycles with baud_tick=1.
  - cnt is $clog2(OVERSAMPLE) bits wide; bit_idx is $clog2(DATA_WIDTH) bits wide.
  - Both clear on every state change.
- IDLE: on a tick with rx_s=0, go to START with cnt=0.
- START:
  - On each tick, cnt++.
  - On the tick where cnt==OVERSAMPLE/2-1, this is mid-start-bit. If rx_s=0, go to DATA. If rx_s=1, treat it as a glitch and return to IDLE with no outputs.
- DATA:
  - On each tick, cnt++.
  - On the tick where cnt==OVERSAMPLE-1, sample rx_s:
    - register bit_out=rx_s and pulse bit_valid for one clk;
    - shift the value into the MSB of the internal shift register (right-shift, so it ends LSB-first);
    - set cnt=0 and bit_idx++.
  - After the sample with bit_idx==DATA_WIDTH-1, go to STOP.
- STOP: on the tick where cnt==OVERSAMPLE-1, sample rx_s.
  - rx_s=1: data_out<=shift register and data_valid pulses.
  - rx_s=0: frame_err pulses and data_out is unchanged.
  - Either way, return to IDLE.
- Output timing:
  - All outputs are registered.
  - A strobe appears the clk after the sampling tick and lasts exactly one clk.
  - data_valid and frame_err are mutually exclusive.
- Back-to-back frames: IDLE re-arms immediately, so a start bit directly following the stop-bit sample is detected.
- A break condition (rx held low) yields frame_err, then a new frame attempt every frame period. No lockout.
- baud_tick held high continuously is legal; each bit then lasts OVERSAMPLE clks.
- Reset asserted mid-frame aborts immediately with no strobe; the next frame starts cleanly.

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA, STOP};
  - default DATA_WIDTH and OVERSAMPLE constants.
- One natural sub-module: sync_2ff, a 2-flop synchroniser with async active-low reset and reset value 1. It is reusable for other UART inputs.

Test Plan:
- Setup for all scenarios: baud_tick=1 every clk, OVERSAMPLE=16, so one bit = 16 clks.
- Send 0xA5 with stop bit 1 -> 8 bit_valid pulses with bit_out sequence 1,0,1,0,0,1,0,1. Then data_out=0xA5, data_valid high exactly one clk, frame_err never high.
- rx low for 4 clks from idle, then high -> busy rises then falls, no bit_valid, data_valid or frame_err, state back to IDLE.
- Send 0x3C with stop bit 0 (data_out previously 0xA5) -> frame_err one-clk pulse, no data_valid, data_out stays 0xA5.
- Frames 0x00 then 0xFF with zero idle between stop and next start -> two data_valid pulses, data_out 0x00 then 0xFF, 16 bit_valid pulses total.
- Assert reset_n=0 during bit 3 of a frame, release, then send 0x5A -> no strobes from the aborted frame; data_out=0x5A after the new frame.
- baud_tick every 4th clk, send 0x81 -> each bit spans 64 clks and data_out=0x81. Feed bit_out/bit_valid into sipo and check sipo parallel_out=0x81 after 8 shifts.
